m_alu_ctrl: RTL and testbench

M_ALU_CTRL -- requirements
Module: m_alu_ctrl

---
 rtl/m_alu_ctrl.sv | 144 ++++++++++++++
 tb/tb_m_alu_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_alu_ctrl.sv
// Program sequencer that issues a stored list of opcode/operand pairs to an ALU.
// Optional divide-by-zero trap: define M_ALU_CTRL_DIV0_TRAP_EN.
module m_alu_ctrl #(
  parameter int unsigned PROG_DEPTH = 8,
  parameter logic [2:0]  DIV_OP     = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [10:0] wr_data,
  input  logic        start,
  input  logic [3:0]  prog_len,
  input  logic        abort,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_data,
  output logic        alu_vld,
  output logic        busy,
  output logic        done,
  output logic [2:0]  pc,
  output logic        err
);

`ifdef M_ALU_CTRL_DIV0_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [10:0] store_r [PROG_DEPTH];
  logic [2:0]  pc_r, pc_nxt_s;
  logic [3:0]  len_r, len_nxt_s;
  logic        err_r, err_nxt_s;
  logic [10:0] entry_s;
  logic        last_s;
  logic        trap_s;
  logic        alu_vld_s;
  logic [2:0]  alu_op_s;
  logic [7:0]  alu_data_s;

  assign entry_s = store_r[pc_r];
  assign last_s  = ({1'b0, pc_r} == (len_r - 4'd1));
  assign trap_s  = TRAP_EN && (entry_s[10:8] == DIV_OP) && (entry_s[7:0] == 8'd0);

  // Program store: writable only while idle so a running program never changes underneath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        store_r[i] <= 11'd0;
      end
    end else if (wr_en && (state_r == IDLE)) begin
      store_r[wr_addr] <= wr_data;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      pc_r    <= 3'd0;
      len_r   <= 4'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      len_r   <= len_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state and ALU issue decode; op/data are combinational from the current entry.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    len_nxt_s   = len_r;
    err_nxt_s   = err_r;
    alu_vld_s   = 1'b0;
    alu_op_s    = 3'd0;
    alu_data_s  = 8'd0;
    case (state_r)
      IDLE: begin
        pc_nxt_s = 3'd0;
        if (start) begin
          if (prog_len > 4'd8) begin
            err_nxt_s = 1'b1;
          end else if (prog_len == 4'd0) begin
            err_nxt_s   = 1'b0;
            state_nxt_s = DONE;
          end else begin
            err_nxt_s   = 1'b0;
            len_nxt_s   = prog_len;
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        alu_op_s   = entry_s[10:8];
        alu_data_s = entry_s[7:0];
        if (trap_s) begin
          // Trapped entry is never presented to the ALU.
          err_nxt_s   = 1'b1;
          state_nxt_s = IDLE;
          pc_nxt_s    = 3'd0;
        end else begin
          alu_vld_s = 1'b1;
          if (abort) begin
            state_nxt_s = IDLE;
            pc_nxt_s    = 3'd0;
          end else if (last_s) begin
            state_nxt_s = DONE;
          end else begin
            pc_nxt_s = pc_r + 3'd1;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = 3'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = 3'd0;
      end
    endcase
  end

  assign alu_vld  = alu_vld_s;
  assign alu_op   = alu_op_s;
  assign alu_data = alu_data_s;
  assign busy     = (state_r != IDLE);
  assign done     = (state_r == DONE);
  assign pc       = pc_r;
  assign err      = err_r;

endmodule

// File: tb/tb_m_alu_ctrl.sv
// Scoreboard bench for m_alu_ctrl: expected issues/done pulses are queued by the
// stimulus and consumed by a negedge monitor.
module tb_m_alu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [10:0] wr_data = 11'd0;
  logic        start = 1'b0;
  logic [3:0]  prog_len = 4'd0;
  logic        abort = 1'b0;
  logic [2:0]  alu_op;
  logic [7:0]  alu_data;
  logic        alu_vld;
  logic        busy;
  logic        done;
  logic [2:0]  pc;
  logic        err;

  typedef struct {
    bit         is_done;
    logic [2:0] op;
    logic [7:0] data;
    logic [2:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  busy_cnt = 0;

  m_alu_ctrl dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .prog_len(prog_len), .abort(abort), .alu_op(alu_op),
    .alu_data(alu_data), .alu_vld(alu_vld), .busy(busy), .done(done), .pc(pc), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_issue(input logic [2:0] op, input logic [7:0] data, input logic [2:0] p);
    ev_t e;
    e.is_done = 1'b0; e.op = op; e.data = data; e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] p);
    ev_t e;
    e.is_done = 1'b1; e.op = 3'd0; e.data = 8'd0; e.pc = p;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] a, input logic [10:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input logic [3:0] len);
    start = 1'b1; prog_len = len;
    tick();
    start = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        ev_t e;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (alu_vld) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_issue", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("issue_kind", {31'd0, e.is_done}, 32'd0);
            chk("alu_op", {29'd0, alu_op}, {29'd0, e.op});
            chk("alu_data", {24'd0, alu_data}, {24'd0, e.data});
            chk("issue_pc", {29'd0, pc}, {29'd0, e.pc});
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_kind", {31'd0, e.is_done}, 32'd1);
            chk("done_pc", {29'd0, pc}, {29'd0, e.pc});
          end
        end
        if (!busy) chk("idle_outputs_zero", {20'd0, alu_vld, alu_op, alu_data}, 32'd0);
      end
    join_none

    // Reset state
    tick();
    chk("reset_outputs", {16'd0, alu_vld, busy, done, err, pc, alu_op, alu_data}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic three-entry program; start in RUN and in DONE is ignored
    wr(3'd0, {3'b000, 8'h05});
    wr(3'd1, {3'b001, 8'h02});
    wr(3'd2, {3'b110, 8'h03});
    push_issue(3'b000, 8'h05, 3'd0);
    push_issue(3'b001, 8'h02, 3'd1);
    push_issue(3'b110, 8'h03, 3'd2);
    push_done(3'd2);
    busy_cnt = 0;
    run(4'd3);
    tick();
    start = 1'b1; prog_len = 4'd1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("run3_busy_cycles", busy_cnt, 32'd4);
    chk("run3_drained", exp_q.size(), 32'd0);

    // Zero-length program, then over-length request
    push_done(3'd0);
    busy_cnt = 0;
    run(4'd0);
    repeat (3) tick();
    chk("len0_busy_cycles", busy_cnt, 32'd1);
    chk("len0_err", {31'd0, err}, 32'd0);
    busy_cnt = 0;
    run(4'd9);
    chk("len9_err", {31'd0, err}, 32'd1);
    repeat (2) tick();
    chk("len9_busy_cycles", busy_cnt, 32'd0);
    chk("len0_drained", exp_q.size(), 32'd0);

    // Abort at pc=3 of an 8-entry program, with a dropped write mid-run
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      a = i[2:0];
      wr(a, {a, 8'h10 + {5'd0, a}});
    end
    for (int i = 0; i < 4; i++) begin
      logic [2:0] a;
      a = i[2:0];
      push_issue(a, 8'h10 + {5'd0, a}, a);
    end
    run(4'd8);
    chk("valid_start_clears_err", {31'd0, err}, 32'd0);
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 11'h7FF;
    tick();
    wr_en = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_to_idle", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("abort_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] a;
      a = i[2:0];
      push_issue(a, 8'h10 + {5'd0, a}, a);
    end
    push_done(3'd7);
    run(4'd8);
    repeat (10) tick();
    chk("readback_drained", exp_q.size(), 32'd0);

    // Divide-by-zero entry
    wr(3'd0, {3'b000, 8'h01});
    wr(3'd1, {3'b101, 8'h00});
    wr(3'd2, {3'b001, 8'h07});
`ifdef M_ALU_CTRL_DIV0_TRAP_EN
    push_issue(3'b000, 8'h01, 3'd0);
    run(4'd3);
    repeat (5) tick();
    chk("div0_err", {31'd0, err}, 32'd1);
`else
    push_issue(3'b000, 8'h01, 3'd0);
    push_issue(3'b101, 8'h00, 3'd1);
    push_issue(3'b001, 8'h07, 3'd2);
    push_done(3'd2);
    run(4'd3);
    repeat (5) tick();
    chk("div0_err", {31'd0, err}, 32'd0);
`endif
    chk("div0_drained", exp_q.size(), 32'd0);

    // Reset at the second issue of a 5-entry run, then restart on first edge
    for (int i = 0; i < 5; i++) begin
      logic [2:0] a;
      a = i[2:0];
      wr(a, {3'b010, 8'h20 + {5'd0, a}});
    end
    push_issue(3'b010, 8'h20, 3'd0);
    run(4'd5);
    tick();
    reset = 1'b0;
    #1;
    chk("midrun_reset_outputs", {16'd0, alu_vld, busy, done, err, pc, alu_op, alu_data}, 32'd0);
    chk("midrun_reset_drained", exp_q.size(), 32'd0);
    push_issue(3'b000, 8'h00, 3'd0);
    push_done(3'd0);
    tick();
    reset = 1'b1;
    run(4'd1);
    repeat (3) tick();
    chk("post_reset_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
